// File: rtl/ps2_mouse_tracker.sv
// ps2_mouse_tracker
//   Decodes the standard 3-byte PS/2 mouse stream and keeps a clamped cursor
//   position plus the left/right button state.
//
//   Ports
//     clk        system clock; all state changes on its rising edge
//     reset      asynchronous active-low reset
//     ps2_clk    raw PS/2 clock from the mouse (asynchronous to clk)
//     ps2_data   raw PS/2 data from the mouse (asynchronous to clk)
//     mouse_x    cursor x, 0..X_MAX
//     mouse_y    cursor y, 0..Y_MAX, screen-down positive
//     btn_l      left button from the last applied packet
//     btn_r      right button from the last applied packet
//     pkt_valid  one-cycle pulse when a packet updates the outputs
//     frame_err  one-cycle pulse on a parity or stop-bit error
module ps2_mouse_tracker #(
    parameter int unsigned X_MAX       = 639,
    parameter int unsigned Y_MAX       = 479,
    parameter int unsigned X_INIT      = 320,
    parameter int unsigned Y_INIT      = 240,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] mouse_x,
    output logic [9:0] mouse_y,
    output logic       btn_l,
    output logic       btn_r,
    output logic       pkt_valid,
    output logic       frame_err
);

    localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYC - 1);
    localparam logic signed [11:0] XMaxS = 12'(X_MAX);
    localparam logic signed [11:0] YMaxS = 12'(Y_MAX);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    // Synchronizers; ps2_clk_last_q holds the previous synchronized clock
    // so a falling edge is last=1, sync=0.
    logic ps2_clk_meta_q, ps2_clk_sync_q, ps2_clk_last_q;
    logic ps2_data_meta_q, ps2_data_sync_q;
    logic fall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps2_clk_meta_q  <= 1'b1;
            ps2_clk_sync_q  <= 1'b1;
            ps2_clk_last_q  <= 1'b1;
            ps2_data_meta_q <= 1'b1;
            ps2_data_sync_q <= 1'b1;
        end else begin
            ps2_clk_meta_q  <= ps2_clk;
            ps2_clk_sync_q  <= ps2_clk_meta_q;
            ps2_clk_last_q  <= ps2_clk_sync_q;
            ps2_data_meta_q <= ps2_data;
            ps2_data_sync_q <= ps2_data_meta_q;
        end
    end

    assign fall = ps2_clk_last_q & ~ps2_clk_sync_q;

    // Frame / packet state
    state_e         state_q;
    logic [2:0]     bit_cnt_q;
    logic [7:0]     shift_q;
    logic           parity_q;
    logic [1:0]     byte_cnt_q;
    logic [ToW-1:0] to_cnt_q;

    // Fields captured from bytes 0 and 1 of the packet in progress
    logic       pend_l_q, pend_r_q;
    logic       x_sign_q, y_sign_q, x_ovf_q, y_ovf_q;
    logic [7:0] byte1_q;

    logic              parity_ok;
    logic              busy;
    logic signed [11:0] dx, dy, x_sum, y_sum;
    logic [9:0]        x_next, y_next;

    assign parity_ok = ^{shift_q, parity_q};
    assign busy      = (state_q != StIdle) || (byte_cnt_q != 2'd0);

    // Position update; shift_q holds byte 2 while the stop bit is sampled.
    always_comb begin
        dx = 12'sd0;
        dy = 12'sd0;
        if (!x_ovf_q) dx = {{4{x_sign_q}}, byte1_q};
        if (!y_ovf_q) dy = {{4{y_sign_q}}, shift_q};
        x_sum = $signed({2'b00, mouse_x}) + dx;
        y_sum = $signed({2'b00, mouse_y}) - dy;

        if (x_sum < 12'sd0)      x_next = 10'd0;
        else if (x_sum > XMaxS)  x_next = XMaxS[9:0];
        else                     x_next = x_sum[9:0];

        if (y_sum < 12'sd0)      y_next = 10'd0;
        else if (y_sum > YMaxS)  y_next = YMaxS[9:0];
        else                     y_next = y_sum[9:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            parity_q   <= 1'b0;
            byte_cnt_q <= 2'd0;
            to_cnt_q   <= '0;
            pend_l_q   <= 1'b0;
            pend_r_q   <= 1'b0;
            x_sign_q   <= 1'b0;
            y_sign_q   <= 1'b0;
            x_ovf_q    <= 1'b0;
            y_ovf_q    <= 1'b0;
            byte1_q    <= 8'd0;
            mouse_x    <= 10'(X_INIT);
            mouse_y    <= 10'(Y_INIT);
            btn_l      <= 1'b0;
            btn_r      <= 1'b0;
            pkt_valid  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            pkt_valid <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                to_cnt_q <= '0;
                unique case (state_q)
                    StIdle: begin
                        // A high start bit is noise; stay idle.
                        if (!ps2_data_sync_q) begin
                            state_q   <= StData;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                    StData: begin
                        shift_q   <= {ps2_data_sync_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= StParity;
                    end
                    StParity: begin
                        parity_q <= ps2_data_sync_q;
                        state_q  <= StStop;
                    end
                    StStop: begin
                        state_q <= StIdle;
                        if (!parity_ok || !ps2_data_sync_q) begin
                            frame_err  <= 1'b1;
                            byte_cnt_q <= 2'd0;
                        end else begin
                            case (byte_cnt_q)
                                2'd0: begin
                                    // Bit 3 is always set in a real header;
                                    // anything else means we are out of sync.
                                    if (shift_q[3]) begin
                                        pend_l_q   <= shift_q[0];
                                        pend_r_q   <= shift_q[1];
                                        x_sign_q   <= shift_q[4];
                                        y_sign_q   <= shift_q[5];
                                        x_ovf_q    <= shift_q[6];
                                        y_ovf_q    <= shift_q[7];
                                        byte_cnt_q <= 2'd1;
                                    end
                                end
                                2'd1: begin
                                    byte1_q    <= shift_q;
                                    byte_cnt_q <= 2'd2;
                                end
                                2'd2: begin
                                    mouse_x    <= x_next;
                                    mouse_y    <= y_next;
                                    btn_l      <= pend_l_q;
                                    btn_r      <= pend_r_q;
                                    pkt_valid  <= 1'b1;
                                    byte_cnt_q <= 2'd0;
                                end
                                default: byte_cnt_q <= 2'd0;
                            endcase
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end else if (busy) begin
                if (to_cnt_q == ToLast) begin
                    state_q    <= StIdle;
                    byte_cnt_q <= 2'd0;
                    to_cnt_q   <= '0;
                end else begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
            end else begin
                to_cnt_q <= '0;
            end
        end
    end

endmodule
